// File: rtl/led_pio_seq_pkg.sv
// Shared types and constants for the LED PIO sequencer and its pattern generator.
package led_pio_seq_pkg;

  localparam int PIO_DW = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_COUNT = 2'd2,
    ST_READ  = 2'd3
  } state_e;

  localparam logic [1:0] MODE_WALK   = 2'b00;
  localparam logic [1:0] MODE_PING   = 2'b01;
  localparam logic [1:0] MODE_COUNT  = 2'b10;
  localparam logic [1:0] MODE_STATIC = 2'b11;

  localparam logic [PIO_DW-1:0] PAT_LO = PIO_DW'(1);
  localparam logic [PIO_DW-1:0] PAT_HI = {1'b1, {(PIO_DW-1){1'b0}}};

  function automatic logic is_onehot(input logic [PIO_DW-1:0] v);
    return (v != '0) && ((v & (v - PIO_DW'(1))) == '0);
  endfunction

endpackage

// File: rtl/led_pattern_gen.sv
// Combinational next-pattern / next-direction rule for the LED sequencer.
module led_pattern_gen
  import led_pio_seq_pkg::*;
(
  input  logic [1:0]        mode_i,
  input  logic [PIO_DW-1:0] pat_i,
  input  logic              dir_left_i,
  output logic [PIO_DW-1:0] next_pat_o,
  output logic              next_dir_left_o
);

  logic go_left;

  always_comb begin
    next_pat_o      = pat_i;
    next_dir_left_o = dir_left_i;
    go_left         = dir_left_i;
    case (mode_i)
      MODE_WALK:  next_pat_o = {pat_i[PIO_DW-2:0], pat_i[PIO_DW-1]};
      MODE_PING: begin
        if (!is_onehot(pat_i)) begin
          next_pat_o      = PAT_LO;
          next_dir_left_o = 1'b1;
        end else begin
          // Endpoints force the direction so a pattern arriving from another mode never shifts out.
          if (pat_i == PAT_LO) begin
            go_left = 1'b1;
          end else if (pat_i == PAT_HI) begin
            go_left = 1'b0;
          end
          next_pat_o = go_left ? {pat_i[PIO_DW-2:0], 1'b0} : {1'b0, pat_i[PIO_DW-1:1]};
          if (next_pat_o == PAT_HI) begin
            next_dir_left_o = 1'b0;
          end else if (next_pat_o == PAT_LO) begin
            next_dir_left_o = 1'b1;
          end else begin
            next_dir_left_o = go_left;
          end
        end
      end
      MODE_COUNT: next_pat_o = pat_i + PIO_DW'(1);
      default: ;
    endcase
  end

endmodule

// File: rtl/led_pio_sequencer.sv
// Autonomous Avalon-MM write master animating the LED PIO at a programmable interval.
// Define LED_PIO_SEQUENCER_READBACK_EN to add a readback cycle with a sticky mismatch flag.
module led_pio_sequencer
  import led_pio_seq_pkg::*;
#(
  parameter int                DIV_W    = 24,
  parameter logic [1:0]        PIO_ADDR = 2'd0,
  parameter logic [PIO_DW-1:0] INIT_PAT = 8'h01
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  div,
  input  logic [PIO_DW-1:0] static_pat,
  output logic [1:0]        pio_address,
  output logic              pio_chipselect,
  output logic              pio_write_n,
  output logic [31:0]       pio_writedata,
  input  logic [31:0]       pio_readdata,
  output logic              busy,
  output logic [PIO_DW-1:0] pattern,
  output logic              mismatch
);

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [PIO_DW-1:0] pat_q, pat_d;
  logic [PIO_DW-1:0] last_q, last_d;
  logic              dir_left_q, dir_left_d;
  logic              cs_q, cs_d;
  logic              wn_q, wn_d;
  logic [31:0]       wd_q, wd_d;
  logic              mis_q, mis_d;
  logic [PIO_DW-1:0] gen_pat;
  logic              gen_dir_left;
  logic [PIO_DW-1:0] wr_src;
  logic [PIO_DW-1:0] wr_val;

  led_pattern_gen u_gen (
    .mode_i          (mode),
    .pat_i           (pat_q),
    .dir_left_i      (dir_left_q),
    .next_pat_o      (gen_pat),
    .next_dir_left_o (gen_dir_left)
  );

  // From IDLE the retained pattern is written as-is; from COUNT the freshly advanced one.
  assign wr_src = (state_q == ST_IDLE) ? pat_q : gen_pat;
  assign wr_val = (mode == MODE_STATIC) ? static_pat : wr_src;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pat_d      = pat_q;
    last_d     = last_q;
    dir_left_d = dir_left_q;
    cs_d       = 1'b0;
    wn_d       = 1'b1;
    wd_d       = wd_q;
    mis_d      = mis_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_WRITE;
          mis_d   = 1'b0;
          cs_d    = 1'b1;
          wn_d    = 1'b0;
          wd_d    = {{(32-PIO_DW){1'b0}}, wr_val};
          last_d  = wr_val;
        end
      end
      ST_WRITE: begin
`ifdef LED_PIO_SEQUENCER_READBACK_EN
        state_d = ST_READ;
        cs_d    = 1'b1;
`else
        if (enable) begin
          state_d = ST_COUNT;
          cnt_d   = div;
        end else begin
          state_d = ST_IDLE;
        end
`endif
      end
      ST_COUNT: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d    = ST_WRITE;
          pat_d      = gen_pat;
          dir_left_d = gen_dir_left;
          cs_d       = 1'b1;
          wn_d       = 1'b0;
          wd_d       = {{(32-PIO_DW){1'b0}}, wr_val};
          last_d     = wr_val;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
`ifdef LED_PIO_SEQUENCER_READBACK_EN
      ST_READ: begin
        if (pio_readdata != {{(32-PIO_DW){1'b0}}, last_q}) begin
          mis_d = 1'b1;
        end
        if (enable) begin
          state_d = ST_COUNT;
          cnt_d   = div;
        end else begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pat_q      <= INIT_PAT;
      last_q     <= INIT_PAT;
      dir_left_q <= 1'b1;
      cs_q       <= 1'b0;
      wn_q       <= 1'b1;
      wd_q       <= '0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pat_q      <= pat_d;
      last_q     <= last_d;
      dir_left_q <= dir_left_d;
      cs_q       <= cs_d;
      wn_q       <= wn_d;
      wd_q       <= wd_d;
      mis_q      <= mis_d;
    end
  end

  assign pio_address    = PIO_ADDR;
  assign pio_chipselect = cs_q;
  assign pio_write_n    = wn_q;
  assign pio_writedata  = wd_q;
  assign busy           = (state_q != ST_IDLE);
  assign pattern        = last_q;

`ifdef LED_PIO_SEQUENCER_READBACK_EN
  assign mismatch = mis_q;
`else
  logic unused_rd;
  assign unused_rd = ^{pio_readdata, mis_q};
  assign mismatch  = 1'b0;
`endif

endmodule

// File: tb/tb_led_pio_sequencer.sv
// Self-checking bench for led_pio_sequencer: vector table, directed corners, randomized model run.
module tb_led_pio_sequencer;

`ifdef LED_PIO_SEQUENCER_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [1:0]  mode;
  logic [23:0] div;
  logic [7:0]  static_pat;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [31:0] pio_readdata;
  logic        busy;
  logic [7:0]  pattern;
  logic        mismatch;

  logic [31:0] pio_reg = 32'h0;
  logic        force_bad = 1'b0;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  led_pio_sequencer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .mode           (mode),
    .div            (div),
    .static_pat     (static_pat),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata),
    .pio_readdata   (pio_readdata),
    .busy           (busy),
    .pattern        (pattern),
    .mismatch       (mismatch)
  );

  // Bench-side PIO slave: data register written on strobe, combinational readback.
  always @(posedge clk) begin
    if (pio_chipselect && !pio_write_n) pio_reg <= pio_writedata;
  end
  assign pio_readdata = force_bad ? 32'h0000_0100 : pio_reg;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else begin
      n_pass++;
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic wait_strobe(output int gap);
    gap = 0;
    do begin
      tick();
      gap++;
    end while (pio_write_n !== 1'b0 && gap < 64);
    if (pio_write_n !== 1'b0) chk("strobe_timeout", 32'(pio_write_n), 32'h0);
  endtask

  typedef struct {
    logic [1:0] m;
    int         dv;
    logic [7:0] sp;
    logic [7:0] exp_data;
    int         exp_gap;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input logic [1:0] m, input int dv, input logic [7:0] sp, input logic [7:0] e);
    vec_t v;
    v.m = m; v.dv = dv; v.sp = sp; v.exp_data = e; v.exp_gap = dv + 2 + RB;
    vecs.push_back(v);
  endtask

  // Reference model: tracks the write schedule and pattern with plain arithmetic.
  int m_phase, m_wait, m_pat, m_last, m_wd, m_step;
  bit m_mis;

  task automatic model_reset();
    m_phase = 0; m_wait = 0; m_pat = 1; m_last = 1; m_wd = 0; m_step = 1; m_mis = 0;
  endtask

  task automatic model_launch();
    m_phase = 1;
    m_last  = (mode == 2'b11) ? int'(static_pat) : m_pat;
    m_wd    = m_last;
  endtask

  task automatic model_advance();
    int pos;
    case (mode)
      2'b00: m_pat = ((m_pat << 1) | (m_pat >> 7)) & 255;
      2'b01: begin
        if ($countones(m_pat) != 1) begin
          m_pat = 1; m_step = 1;
        end else begin
          pos = $clog2(m_pat);
          if (pos == 0) m_step = 1;
          else if (pos == 7) m_step = -1;
          pos = pos + m_step;
          if (pos == 7) m_step = -1;
          else if (pos == 0) m_step = 1;
          m_pat = 1 << pos;
        end
      end
      2'b10: m_pat = (m_pat + 1) % 256;
      default: ;
    endcase
  endtask

  task automatic model_edge();
    if (!reset_n) begin
      model_reset();
      return;
    end
    case (m_phase)
      0: if (enable) begin m_mis = 0; model_launch(); end
      1: begin
        if (RB != 0) m_phase = 2;
        else if (enable) begin m_phase = 3; m_wait = int'(div); end
        else m_phase = 0;
      end
      2: if (enable) begin m_phase = 3; m_wait = int'(div); end else m_phase = 0;
      default: begin
        if (!enable) m_phase = 0;
        else if (m_wait == 0) begin model_advance(); model_launch(); end
        else m_wait--;
      end
    endcase
  endtask

  initial begin
    int gap, tot, iter;
    logic [31:0] exp_v, act_v;

    reset_n = 1'b0; enable = 1'b0; mode = 2'b00; div = 24'd3; static_pat = 8'h00;
    tick(); tick(); tick();
    chk("rst_cs", 32'(pio_chipselect), 32'h0);
    chk("rst_wn", 32'(pio_write_n), 32'h1);
    chk("rst_addr", 32'(pio_address), 32'h0);
    chk("rst_wd", pio_writedata, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_pattern", 32'(pattern), 32'h01);
    chk("rst_mismatch", 32'(mismatch), 32'h0);

    reset_n = 1'b1;
    tick();
    enable = 1'b1;
    wait_strobe(gap);
    chk("first_gap", 32'(gap), 32'd1);
    chk("first_data", pio_writedata, 32'h01);
    chk("first_cs", 32'(pio_chipselect), 32'h1);

    for (int i = 1; i <= 8; i++) add_vec(2'b00, 3, 8'h00, 8'((1 << (i % 8))));
    begin
      int seq[15] = '{2, 4, 8, 16, 32, 64, 128, 64, 32, 16, 8, 4, 2, 1, 2};
      foreach (seq[k]) add_vec(2'b01, 0, 8'h00, 8'(seq[k]));
    end
    add_vec(2'b10, 1, 8'h00, 8'h03);
    add_vec(2'b10, 1, 8'h00, 8'h04);
    add_vec(2'b11, 2, 8'hA5, 8'hA5);
    add_vec(2'b00, 0, 8'h00, 8'h08);

    foreach (vecs[i]) begin
      mode = vecs[i].m; div = 24'(vecs[i].dv); static_pat = vecs[i].sp;
      wait_strobe(gap);
      chk($sformatf("vec%0d_gap", i), 32'(gap), 32'(vecs[i].exp_gap));
      chk($sformatf("vec%0d_data", i), pio_writedata, {24'h0, vecs[i].exp_data});
      chk($sformatf("vec%0d_pattern", i), 32'(pattern), {24'h0, vecs[i].exp_data});
    end

    // Binary count wrap FE -> FF -> 00 with single-cycle strobes.
    mode = 2'b10; div = 24'd0;
    iter = 0;
    do begin
      wait_strobe(gap);
      iter++;
    end while (pio_writedata[7:0] != 8'hFE && iter < 300);
    chk("cnt_reach_fe", pio_writedata, 32'hFE);
    wait_strobe(gap);
    chk("cnt_ff", pio_writedata, 32'hFF);
    tick();
    chk("cnt_ff_wn_1cyc", 32'(pio_write_n), 32'h1);
    wait_strobe(gap);
    chk("cnt_00", pio_writedata, 32'h00);
    tick();
    chk("cnt_00_wn_1cyc", 32'(pio_write_n), 32'h1);

    // Enable dropped during WRITE.
    wait_strobe(gap);
    chk("drop_data", pio_writedata, 32'h01);
    enable = 1'b0;
    for (int k = 0; k < RB; k++) tick();
    chk("drop_busy_held", 32'(busy), 32'h1);
    tick();
    chk("drop_busy_fall", 32'(busy), 32'h0);
    chk("drop_cs", 32'(pio_chipselect), 32'h0);
    tick(); tick(); tick();
    chk("drop_idle_pattern", 32'(pattern), 32'h01);
    enable = 1'b1;
    wait_strobe(gap);
    chk("reen_gap", 32'(gap), 32'd1);
    chk("reen_data", pio_writedata, 32'h01);

    // div changed mid-COUNT only affects the following interval.
    mode = 2'b00; div = 24'd10;
    tick(); tick(); tick();
    div = 24'd2;
    wait_strobe(gap);
    tot = gap + 3;
    chk("div_old_gap", 32'(tot), 32'(12 + RB));
    chk("div_old_data", pio_writedata, 32'h02);
    wait_strobe(gap);
    chk("div_new_gap", 32'(gap), 32'(4 + RB));
    chk("div_new_data", pio_writedata, 32'h04);

    // Reset asserted in the middle of a WRITE.
    reset_n = 1'b0;
    tick();
    chk("rstw_cs", 32'(pio_chipselect), 32'h0);
    chk("rstw_wn", 32'(pio_write_n), 32'h1);
    chk("rstw_pattern", 32'(pattern), 32'h01);
    chk("rstw_busy", 32'(busy), 32'h0);
    reset_n = 1'b1;
    div = 24'd1;

`ifdef LED_PIO_SEQUENCER_READBACK_EN
    wait_strobe(gap);
    tick(); tick();
    chk("rb_good", 32'(mismatch), 32'h0);
    wait_strobe(gap);
    force_bad = 1'b1;
    tick(); tick();
    chk("rb_bad_set", 32'(mismatch), 32'h1);
    force_bad = 1'b0;
    wait_strobe(gap);
    tick(); tick();
    chk("rb_sticky", 32'(mismatch), 32'h1);
    enable = 1'b0;
    tick(); tick(); tick(); tick();
    chk("rb_idle_sticky", {30'h0, busy, mismatch}, 32'h1);
    enable = 1'b1;
    wait_strobe(gap);
    chk("rb_clear", 32'(mismatch), 32'h0);
`endif

    // Randomized run against the reference model.
    enable = 1'b0; reset_n = 1'b0;
    tick(); tick();
    model_reset();
    for (int c = 0; c < 800; c++) begin
      reset_n = ($urandom_range(0, 99) != 0);
      enable  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      div = 24'($urandom_range(0, 3));
      static_pat = 8'($urandom);
      tick();
      model_edge();
      exp_v = {20'h0, m_phase != 0, (m_phase == 1) || (m_phase == 2), m_phase != 1, m_mis, 8'(m_last)};
      act_v = {20'h0, busy, pio_chipselect, pio_write_n, mismatch, pattern};
      chk($sformatf("rand%0d_ctl", c), act_v, exp_v);
      chk($sformatf("rand%0d_wd", c), pio_writedata, 32'(m_wd));
      chk($sformatf("rand%0d_addr", c), 32'(pio_address), 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
